// File: rtl/fk_seq_pkg.sv
// Shared types, widths and the signed angle range check for the FK request sequencer.
package fk_seq_pkg;

    localparam int THETA_W = 13;
    localparam int POS_W   = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        WAIT    = 2'd2,
        GUARD   = 2'd3
    } seq_state_e;

    function automatic logic theta_in_range(input logic signed [THETA_W-1:0] theta, input int lim);
        return (int'(theta) >= -lim) && (int'(theta) <= lim);
    endfunction

endpackage

// File: rtl/period_tick_gen.sv
// Free-running period counter: one-cycle tick every PERIOD_CYCLES enabled cycles.
module period_tick_gen #(
    parameter int PERIOD_CYCLES = 5000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_r;
    logic             at_end_s;

    assign at_end_s = (cnt_r == CNT_W'(PERIOD_CYCLES - 1));
    assign tick     = en && !clr && at_end_s;

    // Period counter: clear has priority, wraps after the terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (at_end_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/fk_sample_sequencer.sv
// Samples and range-checks joint angles, drives one FK request, waits for the
// result under a timeout, then holds a guard interval before the next request.
module fk_sample_sequencer
    import fk_seq_pkg::*;
#(
    parameter int PERIOD_CYCLES  = 5000,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GUARD_CYCLES   = 4,
    parameter int TH_LIM         = 4000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      run,
    input  logic                      single,
    input  logic                      clear_err,
    input  logic signed [THETA_W-1:0] theta1_in,
    input  logic signed [THETA_W-1:0] theta2_in,
    output logic signed [THETA_W-1:0] fk_theta1,
    output logic signed [THETA_W-1:0] fk_theta2,
    output logic                      fk_enable,
    input  logic [POS_W-1:0]          fk_x,
    input  logic [POS_W-1:0]          fk_y,
    input  logic                      fk_ready,
    output logic [POS_W-1:0]          x_pos,
    output logic [POS_W-1:0]          y_pos,
    output logic                      pos_valid,
    output logic                      busy,
    output logic                      timeout_err,
    output logic                      limit_err,
    output logic                      overrun_err,
    output logic [15:0]               sample_count
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             tick_s;
    logic             trigger_s;
    logic             range_ok_s;
    logic             timeout_hit_s;
    logic             guard_done_s;
    logic             limit_set_s;
    logic             overrun_set_s;
    logic             timeout_set_s;

    period_tick_gen #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_period (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (run),
        .clr    (~run),
        .tick   (tick_s)
    );

    // A tick and a single in the same cycle merge into one trigger.
    assign trigger_s     = single | tick_s;
    assign range_ok_s    = theta_in_range(theta1_in, TH_LIM) && theta_in_range(theta2_in, TH_LIM);
    assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    assign guard_done_s  = (cnt_r == CNT_W'(GUARD_CYCLES - 1));
    assign limit_set_s   = (state_r == IDLE) && trigger_s && !range_ok_s;
    assign overrun_set_s = (state_r != IDLE) && tick_s;
    assign timeout_set_s = (state_r == WAIT) && !fk_ready && timeout_hit_s;

    // Request FSM; one counter serves both the WAIT timeout and the GUARD interval.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            fk_theta1    <= '0;
            fk_theta2    <= '0;
            fk_enable    <= 1'b0;
            x_pos        <= '0;
            y_pos        <= '0;
            pos_valid    <= 1'b0;
            busy         <= 1'b0;
            sample_count <= 16'd0;
        end else begin
            fk_enable <= 1'b0;
            pos_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (trigger_s && range_ok_s) begin
                        fk_theta1 <= theta1_in;
                        fk_theta2 <= theta2_in;
                        fk_enable <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= REQUEST;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                REQUEST: begin
                    cnt_r   <= '0;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (fk_ready) begin
                        x_pos        <= fk_x;
                        y_pos        <= fk_y;
                        sample_count <= sample_count + 16'd1;
                        pos_valid    <= 1'b1;
                        cnt_r        <= '0;
                        state_r      <= GUARD;
                    end else if (timeout_hit_s) begin
                        cnt_r   <= '0;
                        state_r <= GUARD;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                GUARD: begin
                    if (guard_done_s) begin
                        cnt_r   <= '0;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Sticky fault flags; a set event outranks clear_err in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
            limit_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            timeout_err <= timeout_set_s | (timeout_err & ~clear_err);
            limit_err   <= limit_set_s   | (limit_err   & ~clear_err);
            overrun_err <= overrun_set_s | (overrun_err & ~clear_err);
        end
    end

endmodule

// File: tb/tb_fk_sample_sequencer.sv
// Directed bench for fk_sample_sequencer with a fixed-latency FK responder model.
module tb_fk_sample_sequencer;

    localparam int PERIOD = 300;
    localparam int LAT    = 114;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic run = 1'b0;
    logic single = 1'b0;
    logic clear_err = 1'b0;
    logic signed [12:0] theta1_in = 13'sd0;
    logic signed [12:0] theta2_in = 13'sd0;
    logic signed [12:0] fk_theta1;
    logic signed [12:0] fk_theta2;
    logic        fk_enable;
    logic [13:0] fk_x = 14'd0;
    logic [13:0] fk_y = 14'd0;
    logic        fk_ready = 1'b0;
    logic [13:0] x_pos;
    logic [13:0] y_pos;
    logic        pos_valid;
    logic        busy;
    logic        timeout_err;
    logic        limit_err;
    logic        overrun_err;
    logic [15:0] sample_count;

    logic [13:0] rsp_x = 14'd0;
    logic [13:0] rsp_y = 14'd0;
    logic        fk_answer = 1'b1;
    int          fk_cnt = 0;

    int cyc = 0;
    int en_cnt = 0;
    int en_last = -1;
    int en_double = 0;
    logic en_prev = 1'b0;
    int pv_cnt = 0;

    int n_tests = 0;
    int n_fail = 0;

    fk_sample_sequencer #(
        .PERIOD_CYCLES (PERIOD),
        .TIMEOUT_CYCLES(255),
        .GUARD_CYCLES  (4),
        .TH_LIM        (4000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .single      (single),
        .clear_err   (clear_err),
        .theta1_in   (theta1_in),
        .theta2_in   (theta2_in),
        .fk_theta1   (fk_theta1),
        .fk_theta2   (fk_theta2),
        .fk_enable   (fk_enable),
        .fk_x        (fk_x),
        .fk_y        (fk_y),
        .fk_ready    (fk_ready),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .pos_valid   (pos_valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .limit_err   (limit_err),
        .overrun_err (overrun_err),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    // Cycle counter: after edge e, cyc == e.
    always @(posedge clk) cyc <= cyc + 1;

    // FK responder: fk_ready for one cycle LAT cycles after it sees fk_enable; ignores reset_n.
    always @(posedge clk) begin
        fk_ready <= 1'b0;
        if (fk_enable) begin
            fk_cnt <= LAT;
        end else if (fk_cnt != 0) begin
            fk_cnt <= fk_cnt - 1;
            if (fk_cnt == 1 && fk_answer) begin
                fk_ready <= 1'b1;
                fk_x     <= rsp_x;
                fk_y     <= rsp_y;
            end
        end
    end

    // Pulse monitors for fk_enable and pos_valid.
    always @(posedge clk) begin
        en_prev <= fk_enable;
        if (fk_enable) begin
            en_cnt  <= en_cnt + 1;
            en_last <= cyc;
        end
        if (fk_enable && en_prev) en_double <= en_double + 1;
        if (pos_valid) pv_cnt <= pv_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_single();
        single = 1'b1;
        step(1);
        single = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
    endtask

    task automatic wait_pv(input string tag, input int budget);
        int n = 0;
        while (!pos_valid && n < budget) begin @(negedge clk); n++; end
        check_eq({tag, " pos_valid seen"}, {31'd0, pos_valid}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin @(negedge clk); n++; end
        check_eq({tag, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int t0;
        int e0;
        int p0;
        int n;
        logic [15:0] s0;

        // Reset values
        step(3);
        check_eq("rst theta1", fk_theta1, 13'sd0);
        check_eq("rst theta2", fk_theta2, 13'sd0);
        check_eq("rst enable", fk_enable, 1'b0);
        check_eq("rst xy", {x_pos, y_pos}, 28'd0);
        check_eq("rst pv/busy", {pos_valid, busy}, 2'b00);
        check_eq("rst errs", {timeout_err, limit_err, overrun_err}, 3'b000);
        check_eq("rst count", sample_count, 16'd0);
        reset_n = 1'b1;
        step(2);

        // Single request, trigger-to-pos_valid = LAT + 3, guard of 4 cycles
        theta1_in = 13'sd100; theta2_in = -13'sd200;
        rsp_x = 14'h1234; rsp_y = 14'h0567; fk_answer = 1'b1;
        e0 = en_cnt; p0 = pv_cnt; t0 = cyc;
        pulse_single();
        check_eq("single theta1", fk_theta1, 13'sd100);
        check_eq("single theta2", fk_theta2, -13'sd200);
        check_eq("single busy", busy, 1'b1);
        theta1_in = 13'sd7; theta2_in = 13'sd9;
        wait_pv("single", 400);
        check_eq("single latency", cyc - t0, LAT + 3);
        check_eq("single x", x_pos, 14'h1234);
        check_eq("single y", y_pos, 14'h0567);
        check_eq("single count", sample_count, 16'd1);
        check_eq("single theta hold", fk_theta1, 13'sd100);
        repeat (3) @(negedge clk);
        check_eq("guard busy", busy, 1'b1);
        @(negedge clk);
        check_eq("guard end", busy, 1'b0);
        step(5);
        check_eq("single enables", en_cnt - e0, 1);
        check_eq("single pvs", pv_cnt - p0, 1);

        // Range limits
        e0 = en_cnt;
        theta1_in = 13'sd4001; theta2_in = 13'sd0;
        pulse_single();
        step(3);
        check_eq("lim +4001 err", limit_err, 1'b1);
        check_eq("lim busy", busy, 1'b0);
        check_eq("lim theta kept", fk_theta1, 13'sd100);
        check_eq("lim no enable", en_cnt - e0, 0);
        pulse_clear();
        check_eq("lim clear", limit_err, 1'b0);
        theta1_in = 13'sd0; theta2_in = -13'sd4001;
        pulse_single();
        step(2);
        check_eq("lim -4001 err", limit_err, 1'b1);
        pulse_clear();
        theta1_in = -13'sd4000; theta2_in = 13'sd4000;
        rsp_x = 14'h0ABC; rsp_y = 14'h3FFF;
        pulse_single();
        check_eq("lim edge theta1", fk_theta1, -13'sd4000);
        check_eq("lim edge theta2", fk_theta2, 13'sd4000);
        check_eq("lim edge no err", limit_err, 1'b0);
        wait_pv("lim edge", 400);
        check_eq("lim edge xy", {x_pos, y_pos}, {14'h0ABC, 14'h3FFF});
        check_eq("lim edge count", sample_count, 16'd2);
        wait_idle("lim edge", 20);

        // Timeout: FK never answers
        step(2);
        fk_answer = 1'b0; theta1_in = 13'sd5; theta2_in = 13'sd5;
        p0 = pv_cnt; t0 = cyc;
        pulse_single();
        n = 0;
        while (!timeout_err && n < 400) begin @(negedge clk); n++; end
        check_eq("to flag", timeout_err, 1'b1);
        check_eq("to cycle", cyc - t0, 257);
        check_eq("to x kept", x_pos, 14'h0ABC);
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        check_eq("to idle cycle", cyc - t0, 261);
        check_eq("to no pv", pv_cnt - p0, 0);
        check_eq("to count", sample_count, 16'd2);
        pulse_clear();
        check_eq("to clear", timeout_err, 1'b0);
        fk_answer = 1'b1;

        // Periodic mode: requests at cycles 300, 600, 900
        rsp_x = 14'h0111; rsp_y = 14'h0222;
        e0 = en_cnt; p0 = pv_cnt; s0 = sample_count; t0 = cyc;
        run = 1'b1;
        wait_until(t0 + 310);
        check_eq("per first", en_cnt - e0, 1);
        check_eq("per first cyc", en_last - t0, PERIOD);
        wait_until(t0 + 910);
        run = 1'b0;
        check_eq("per three", en_cnt - e0, 3);
        check_eq("per third cyc", en_last - t0, 3 * PERIOD);
        wait_until(t0 + 1100);
        check_eq("per pvs", pv_cnt - p0, 3);
        check_eq("per count", sample_count, s0 + 16'd3);
        check_eq("per x", x_pos, 14'h0111);
        check_eq("per overrun", overrun_err, 1'b0);

        // Overrun, clear/set collision, single/tick collision
        e0 = en_cnt; t0 = cyc;
        run = 1'b1;
        wait_until(t0 + 249);
        pulse_single();
        wait_until(t0 + 310);
        check_eq("ovr set", overrun_err, 1'b1);
        wait_until(t0 + 400);
        check_eq("ovr not queued", en_cnt - e0, 1);
        check_eq("ovr idle", busy, 1'b0);
        pulse_clear();
        check_eq("ovr clear", overrun_err, 1'b0);
        wait_until(t0 + 849);
        pulse_single();
        wait_until(t0 + 899);
        pulse_clear();
        check_eq("ovr set beats clear", overrun_err, 1'b1);
        wait_until(t0 + 1000);
        check_eq("ovr enables", en_cnt - e0, 3);
        pulse_clear();
        check_eq("ovr clear2", overrun_err, 1'b0);
        wait_until(t0 + 1199);
        e0 = en_cnt; s0 = sample_count;
        pulse_single();
        wait_until(t0 + 1350);
        run = 1'b0;
        check_eq("coll one request", en_cnt - e0, 1);
        check_eq("coll count", sample_count, s0 + 16'd1);
        check_eq("coll no overrun", overrun_err, 1'b0);

        // Reset in the middle of WAIT, FK answers afterwards
        wait_idle("pre reset", 300);
        step(1);
        theta1_in = 13'sd300; theta2_in = -13'sd300;
        p0 = pv_cnt; t0 = cyc;
        pulse_single();
        wait_until(t0 + 52);
        check_eq("mid wait busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("mrst theta", {fk_theta1, fk_theta2}, 26'd0);
        check_eq("mrst enable/pv/busy", {fk_enable, pos_valid, busy}, 3'b000);
        check_eq("mrst xy", {x_pos, y_pos}, 28'd0);
        check_eq("mrst count", sample_count, 16'd0);
        check_eq("mrst errs", {timeout_err, limit_err, overrun_err}, 3'b000);
        step(3);
        reset_n = 1'b1;
        wait_until(t0 + 200);
        check_eq("mrst no pv", pv_cnt - p0, 0);
        check_eq("mrst idle", busy, 1'b0);
        check_eq("mrst count after", sample_count, 16'd0);
        check_eq("mrst x after", x_pos, 14'd0);
        check_eq("enable single-cycle", en_double, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fk_sample_sequencer.md
# fk_sample_sequencer

Upstream request sequencer for the forward-kinematics (FK) stage. It samples the two joint angles periodically or on demand and range-checks them. It holds them stable on the FK theta inputs for the whole computation, pulses the FK enable, and waits for FK data-ready under a timeout. It then latches x/y into a one-cycle-valid result for the motion controller.

## Interface
- PERIOD_CYCLES, 5000: cycles between automatic requests when `run`=1 (100 µs at 50 MHz); must be ≥ TIMEOUT_CYCLES+GUARD_CYCLES+3.
- TIMEOUT_CYCLES, 255: maximum WAIT cycles for `fk_ready`; must exceed FK latency (114).
- GUARD_CYCLES, 4: idle cycles after completion/timeout so FK returns to its init state before the next request.
- TH_LIM, 4000: accepted angle range, inclusive, is −TH_LIM..+TH_LIM.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; enables periodic requests.
- single  in  1  one-cycle pulse; requests one computation.
- clear_err  in  1  one-cycle pulse; clears sticky error flags.
- theta1_in, theta2_in  in  13 signed  live joint angles, FK fixed-point format.
- fk_theta1, fk_theta2  out  13 signed  held angles driven to FK.
- fk_enable  out  1  one-cycle request pulse to FK.
- fk_x, fk_y  in  14  FK results.
- fk_ready  in  1  FK data-ready.
- x_pos, y_pos  out  14  latched results.
- pos_valid  out  1  one-cycle pulse when x_pos/y_pos update.
- busy  out  1  high in any state other than IDLE.
- timeout_err, limit_err, overrun_err  out  1 each  sticky fault flags.
- sample_count  out  16  successful completions; wraps 0xFFFF→0.

## Operation
- States: IDLE, REQUEST, WAIT, GUARD.
- Trigger: `single`, or the period tick while `run`=1. A simultaneous tick and `single` produce one request.
- IDLE with trigger, both angles in range: register theta*_in into fk_theta*, then go to REQUEST.
- IDLE with trigger, either angle out of range: set limit_err, stay in IDLE, leave fk_theta* unchanged, issue no request.
- REQUEST: fk_enable=1 for this cycle only; clear the timeout counter; go to WAIT.
- WAIT with fk_ready=1: latch fk_x/fk_y, increment sample_count, pulse pos_valid next cycle, go to GUARD.
- WAIT timeout: after TIMEOUT_CYCLES cycles without fk_ready, set timeout_err and go to GUARD. x_pos/y_pos keep their old values and pos_valid stays low.
- GUARD: stay exactly GUARD_CYCLES cycles, then go to IDLE. fk_theta* hold through WAIT and GUARD.
- fk_ready outside WAIT is ignored. Only the first fk_ready cycle in WAIT counts.
- `single` outside IDLE is dropped silently.
- Period tick outside IDLE sets overrun_err; no request is queued.
- Period timer counts only while `run`=1. It resets to 0 when `run` falls, and the first tick comes PERIOD_CYCLES cycles after `run` rises.
- clear_err clears all three flags. If a set event and clear_err occur in the same cycle, the set wins.
- Range check is signed: −TH_LIM ≤ θ ≤ TH_LIM.

## Timing
- All outputs are registered.
- Reset values: fk_theta*=0, fk_enable=0, x_pos=y_pos=0, pos_valid=0, busy=0, all error flags=0, sample_count=0; state=IDLE; period counter=0.
- Trigger sampled at edge k → fk_theta* valid after k, fk_enable high in cycle k+1, WAIT from k+2.
- fk_ready sampled at edge m → x_pos/y_pos and sample_count update at m, pos_valid high in cycle m+1 only, GUARD from m+1 through m+GUARD_CYCLES, IDLE at m+GUARD_CYCLES+1.
- Trigger-to-pos_valid = FK latency + 3 cycles.
- Reset mid-operation aborts immediately to the reset values; no pos_valid is emitted. The top level ties the FK reset to ~reset_n so both blocks restart together.

## Structure
- Package fk_seq_pkg: state enum typedef (IDLE, REQUEST, WAIT, GUARD) and constants THETA_W=13, POS_W=14.
- One sub-module, `period_tick_gen`: parameterised counter with count-enable, synchronous clear and asynchronous active-low reset; emits a one-cycle tick at PERIOD_CYCLES−1.
- Timeout and guard counting share one counter inside the main FSM.

## Test plan
- Single request: single pulse, θ1=100, θ2=−200, FK model answers after 114 cycles with x=0x1234, y=0x0567 → fk_enable is exactly one pulse; fk_theta*=100/−200 held until IDLE; pos_valid is one pulse with x_pos=0x1234, y_pos=0x0567; sample_count=1.
- Periodic mode: run=1, PERIOD_CYCLES=300 → requests at cycles 300, 600, 900; three pos_valid pulses; overrun_err stays 0.
- Timeout: FK model never asserts fk_ready → timeout_err=1 after 255 WAIT cycles; x_pos unchanged; IDLE 4 cycles later. clear_err → flag 0.
- Limit: θ1=4001 with single → limit_err=1, fk_enable never asserts, busy stays 0. θ1=−4000 is accepted.
- Overrun and collisions: PERIOD_CYCLES shortened below FK latency → overrun_err=1. single together with tick → one request. clear_err in the same cycle as a new overrun → flag stays 1.
- Reset mid-WAIT: reset_n low at cycle 50 of WAIT, then FK asserts fk_ready → all outputs at reset values, no pos_valid, state IDLE.
